// File: rtl/packet_accumulator.sv
// Packet accumulator: sums operand beats through an 8-bit ripple adder and presents the
// packet total, sticky carry flag and saturating beat count on a valid/ready output.
module packet_accumulator #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_ovf,
    output logic [CNT_WIDTH-1:0] out_count
);

    typedef enum logic [0:0] {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]     ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]     ZERO_W   = {WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Bit-serial ripple add; the carry-out is recovered from the operand/sum MSBs instead.
    function automatic logic [WIDTH-1:0] ripple_add(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] s;
        logic             c;
        s = ZERO_W;
        c = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
        end
        return s;
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [WIDTH-1:0]       acc_r, acc_nxt_s;
    logic                   ovf_r, ovf_nxt_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]       out_data_r, out_data_nxt_s;
    logic                   out_ovf_r, out_ovf_nxt_s;
    logic [CNT_WIDTH-1:0]   out_count_r, out_count_nxt_s;

    logic                   beat_s;
    logic [WIDTH-1:0]       add_s;
    logic                   co_s;
    logic [WIDTH-1:0]       sum_nxt_s;
    logic                   ovf_beat_s;
    logic [CNT_WIDTH-1:0]   cnt_beat_s;

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    assign in_ready  = (state_r == ACC);
    assign out_valid = (state_r == OUT);
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;
    assign out_count = out_count_r;

    assign beat_s = in_valid & (state_r == ACC);

    // Per-beat arithmetic: sum, carry, clamp and saturating count for the accepted beat.
    always_comb begin
        add_s      = ripple_add(acc_r, in_data);
        co_s       = (acc_r[WIDTH-1] & in_data[WIDTH-1]) |
                     ((acc_r[WIDTH-1] ^ in_data[WIDTH-1]) & ~add_s[WIDTH-1]);
        ovf_beat_s = ovf_r | co_s;
        // A clamped accumulator is all-ones, so any later non-zero operand carries again.
        if (SATURATE && (co_s || ovf_r)) begin
            sum_nxt_s = ALL_ONES;
        end else begin
            sum_nxt_s = add_s;
        end
        if (cnt_r == CNT_MAX) begin
            cnt_beat_s = CNT_MAX;
        end else begin
            cnt_beat_s = cnt_r + CNT_ONE;
        end
    end

    // Next-state and next-register logic for the accumulate/present FSM.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        ovf_nxt_s       = ovf_r;
        cnt_nxt_s       = cnt_r;
        out_data_nxt_s  = out_data_r;
        out_ovf_nxt_s   = out_ovf_r;
        out_count_nxt_s = out_count_r;
        case (state_r)
            ACC: begin
                if (beat_s && in_last) begin
                    out_data_nxt_s  = sum_nxt_s;
                    out_ovf_nxt_s   = ovf_beat_s;
                    out_count_nxt_s = cnt_beat_s;
                    acc_nxt_s       = ZERO_W;
                    ovf_nxt_s       = 1'b0;
                    cnt_nxt_s       = CNT_ZERO;
                    state_nxt_s     = OUT;
                end else if (beat_s) begin
                    acc_nxt_s       = sum_nxt_s;
                    ovf_nxt_s       = ovf_beat_s;
                    cnt_nxt_s       = cnt_beat_s;
                    state_nxt_s     = ACC;
                end else begin
                    state_nxt_s     = ACC;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt_s = ACC;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: begin
                state_nxt_s = ACC;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ACC;
            acc_r       <= ZERO_W;
            ovf_r       <= 1'b0;
            cnt_r       <= CNT_ZERO;
            out_data_r  <= ZERO_W;
            out_ovf_r   <= 1'b0;
            out_count_r <= CNT_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            ovf_r       <= ovf_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_ovf_r   <= out_ovf_nxt_s;
            out_count_r <= out_count_nxt_s;
        end
    end

endmodule

// File: tb/tb_packet_accumulator.sv
// Self-checking bench: a wrapping and a saturating accumulator share one stimulus stream and
// are compared against packet totals computed with plain integer arithmetic.
module tb_packet_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready_w, out_valid_w, out_ovf_w;
    logic [7:0] out_data_w;
    logic [3:0] out_count_w;
    logic       in_ready_s, out_valid_s, out_ovf_s;
    logic [7:0] out_data_s;
    logic [3:0] out_count_s;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] pkt_q[$];

    packet_accumulator #(.WIDTH(8), .CNT_WIDTH(4), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data(out_data_w), .out_ovf(out_ovf_w), .out_count(out_count_w)
    );

    packet_accumulator #(.WIDTH(8), .CNT_WIDTH(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_ovf(out_ovf_s), .out_count(out_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int waited;
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        while (!(in_ready_w && in_ready_s) && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check_eq("in_ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Sends pkt_q as one packet, holds the result for bp cycles, then accepts it.
    task automatic run_packet(input int bp);
        int         sum;
        int         n;
        logic [7:0] e_wrap, e_sat;
        logic       e_ovf;
        logic [3:0] e_cnt;
        sum = 0;
        n   = pkt_q.size();
        foreach (pkt_q[i]) sum += int'(pkt_q[i]);
        e_wrap = 8'(sum % 256);
        e_sat  = (sum > 255) ? 8'hFF : 8'(sum);
        e_ovf  = (sum > 255);
        e_cnt  = (n > 15) ? 4'hF : 4'(n);
        foreach (pkt_q[i]) send_beat(pkt_q[i], (i == n - 1));
        check_eq("out_valid_after_last", {30'd0, out_valid_w, out_valid_s}, 32'd3);
        check_eq("in_ready_in_out", {30'd0, in_ready_w, in_ready_s}, 32'd0);
        check_eq("out_data_wrap", 32'(out_data_w), 32'(e_wrap));
        check_eq("out_data_sat", 32'(out_data_s), 32'(e_sat));
        check_eq("out_ovf", {30'd0, out_ovf_w, out_ovf_s}, {30'd0, e_ovf, e_ovf});
        check_eq("out_count", {24'd0, out_count_w, out_count_s}, {24'd0, e_cnt, e_cnt});
        for (int k = 0; k < bp; k++) begin
            out_ready = 1'b0;
            tick();
            check_eq("bp_valid_ready", {28'd0, out_valid_w, out_valid_s, in_ready_w, in_ready_s},
                     32'hC);
            check_eq("bp_data_stable", {16'd0, out_data_w, out_data_s}, {16'd0, e_wrap, e_sat});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("post_xfer_valid_ready", {28'd0, out_valid_w, out_valid_s, in_ready_w, in_ready_s},
                 32'h3);
        check_eq("post_xfer_retained", {12'd0, out_data_w, out_data_s, out_count_w},
                 {12'd0, e_wrap, e_sat, e_cnt});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_last   = 1'b1;
        out_ready = 1'b0;

        // Reset held three cycles with a beat offered: nothing may be captured.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_out_valid", {30'd0, out_valid_w, out_valid_s}, 32'd0);
            check_eq("rst_out_data", {16'd0, out_data_w, out_data_s}, 32'd0);
            check_eq("rst_out_count", {24'd0, out_count_w, out_count_s}, 32'd0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        check_eq("rst_in_ready", {30'd0, in_ready_w, in_ready_s}, 32'd3);

        pkt_q = {8'h02, 8'h02};
        run_packet(0);
        pkt_q = {8'h92, 8'hAB};
        run_packet(1);
        pkt_q = {8'h01, 8'h03};
        run_packet(5);

        // Reset in the middle of a packet discards the partial sum.
        send_beat(8'h10, 1'b0);
        send_beat(8'h20, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("midrst_out_data", {16'd0, out_data_w, out_data_s}, 32'd0);
        pkt_q = {8'h05};
        run_packet(0);

        pkt_q = {};
        for (int i = 0; i < 17; i++) pkt_q.push_back(8'h01);
        run_packet(0);
        pkt_q = {8'hFF};
        run_packet(0);

        for (int p = 0; p < 25; p++) begin
            int len;
            len   = $urandom_range(1, 20);
            pkt_q = {};
            for (int i = 0; i < len; i++) begin
                if (p % 3 == 0) pkt_q.push_back(8'($urandom_range(0, 15)));
                else            pkt_q.push_back(8'($urandom));
            end
            run_packet($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
